// File: rtl/uart_tx_if.sv
// Handshake bundle between the command/control logic and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    // Requesting side: supplies the baud tick and the byte to send.
    modport master (
        output tick,
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  tick,
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter paced by a 16x-oversample baud tick.
// Frame: start bit, DATA_BITS data bits LSB first, stop bit held STOP_TICKS ticks.
// tx, tx_busy and tx_done are flops loaded from next-state values.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_TICKS = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);
    localparam int CNT_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
    localparam int TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 tx_r, tx_n;
    logic                 busy_r, busy_n;
    logic                 done_r, done_n;

    // State, counters, latched byte and the three registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            tx_r     <= tx_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
        end
    end

    // Next-state and next-output logic; outputs follow the state being entered.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;

        unique case (state)
            IDLE: begin
                // Acceptance is not gated by tick; a coincident tick is not counted.
                if (bus.tx_start) begin
                    shift_n    = bus.tx_data;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (bus.tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_n = '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt_n = '0;
                            state_n   = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        done_n = (state == STOP) && (state_n == IDLE);
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[bit_cnt_n];
            default: tx_n = 1'b1;
        endcase
    end

    assign bus.tx      = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx against a tick-counting frame model and a
// behavioural 16x-oversampled receiver on the serial line.
module tb_uart_tx;
    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int STOP_TICKS  = 16;
    localparam int FRAME_TICKS = OVERSAMPLE * (1 + DATA_BITS) + STOP_TICKS;
    localparam int DATA_END    = OVERSAMPLE * (1 + DATA_BITS);

    logic clk = 1'b0;
    logic reset;

    uart_tx_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_tx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .STOP_TICKS(STOP_TICKS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame model: ticks elapsed since acceptance decide the line level.
    bit                   m_active = 1'b0;
    int                   m_t      = 0;
    logic [DATA_BITS-1:0] m_byte   = '0;
    bit                   m_done   = 1'b0;

    function automatic logic exp_tx();
        if (!m_active)        return 1'b1;
        if (m_t < OVERSAMPLE) return 1'b0;
        if (m_t < DATA_END)   return m_byte[(m_t - OVERSAMPLE) / OVERSAMPLE];
        return 1'b1;
    endfunction

    // Receiver model.
    bit                   rx_on   = 1'b0;
    int                   rx_cnt  = 0;
    logic [DATA_BITS-1:0] rx_sh   = '0;
    logic [DATA_BITS-1:0] rx_q[$];
    int                   rx_ferr = 0;

    task automatic rx_step(input logic line);
        int k;
        if (!rx_on) begin
            if (line == 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == OVERSAMPLE / 2) begin
                if (line != 1'b0) rx_on = 1'b0;
            end else if (rx_cnt > OVERSAMPLE / 2 && (rx_cnt - OVERSAMPLE / 2) % OVERSAMPLE == 0) begin
                k = (rx_cnt - OVERSAMPLE / 2) / OVERSAMPLE;
                if (k <= DATA_BITS) begin
                    rx_sh[k-1] = line;
                end else begin
                    if (line) rx_q.push_back(rx_sh);
                    else      rx_ferr++;
                    rx_on = 1'b0;
                end
            end
        end
    endtask

    int tick_per   = 4;
    int tick_phase = 0;
    int busy_ticks = 0;
    int done_cnt   = 0;

    task automatic cycle(input logic st, input logic [DATA_BITS-1:0] d);
        logic tk;
        if (tick_per == 0) begin
            tk = 1'b0;
        end else if (tick_per < 0) begin
            tk = ($urandom_range(0, 2) == 0);
        end else begin
            tick_phase++;
            if (tick_phase >= tick_per) begin
                tick_phase = 0;
                tk = 1'b1;
            end else begin
                tk = 1'b0;
            end
        end
        bus.tick     = tk;
        bus.tx_start = st;
        bus.tx_data  = d;
        if (tk && bus.tx_busy) busy_ticks++;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (m_active) begin
            if (tk) begin
                m_t++;
                if (m_t == FRAME_TICKS) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (st) begin
            m_active = 1'b1;
            m_t      = 0;
            m_byte   = d;
        end
        check("tx", bus.tx, exp_tx());
        check("busy", bus.tx_busy, m_active);
        check("done", bus.tx_done, m_done);
        if (bus.tx_done) done_cnt++;
        if (tk) rx_step(bus.tx);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 20000) begin
            cycle(1'b0, DATA_BITS'($urandom));
            n++;
        end
        check("frame_timeout", m_active, 1'b0);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] b);
        cycle(1'b1, b);
        wait_idle();
    endtask

    task automatic do_reset();
        bus.tx_start = 1'b0;
        bus.tick     = 1'b0;
        reset        = 1'b1;
        #1;
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_done", bus.tx_done, 1'b0);
        m_active = 1'b0;
        m_t      = 0;
        m_done   = 1'b0;
        rx_on    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_tx", bus.tx, 1'b1);
            check("rst_hold_busy", bus.tx_busy, 1'b0);
            check("rst_hold_done", bus.tx_done, 1'b0);
        end
        reset = 1'b0;
    endtask

    task automatic expect_rx(input int n, input logic [DATA_BITS-1:0] a, input logic [DATA_BITS-1:0] b);
        check("rx_count", rx_q.size(), n);
        if (rx_q.size() >= 1) check("rx_byte0", rx_q[0], a);
        if (n > 1 && rx_q.size() >= 2) check("rx_byte1", rx_q[1], b);
        check("rx_framing", rx_ferr, 0);
        rx_q.delete();
        rx_ferr = 0;
    endtask

    initial begin
        int n;
        bit prev_done;
        logic [DATA_BITS-1:0] rb;

        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_tx", bus.tx, 1'b1);
        check("init_busy", bus.tx_busy, 1'b0);
        check("init_done", bus.tx_done, 1'b0);
        reset = 1'b0;
        repeat (3) cycle(1'b0, '0);

        // Reset after three data bits, then a clean 0xA5 frame.
        tick_per = 4;
        cycle(1'b1, 8'hC3);
        n = 0;
        while (m_t < OVERSAMPLE * 4 && n < 5000) begin
            cycle(1'b0, '0);
            n++;
        end
        do_reset();
        rx_q.delete();
        rx_ferr = 0;
        repeat (3) cycle(1'b0, '0);
        send_frame(8'hA5);
        repeat (5) cycle(1'b0, '0);
        expect_rx(1, 8'hA5, 8'h00);

        // Single 0x52 with a tick every 4 clocks.
        busy_ticks = 0;
        done_cnt   = 0;
        send_frame(8'h52);
        repeat (10) cycle(1'b0, '0);
        check("busy_ticks", busy_ticks, FRAME_TICKS);
        check("done_pulses", done_cnt, 1);
        expect_rx(1, 8'h52, 8'h00);

        // Request while busy is ignored.
        done_cnt = 0;
        cycle(1'b1, 8'hFF);
        repeat (100) cycle(1'b0, DATA_BITS'($urandom));
        cycle(1'b1, 8'h00);
        wait_idle();
        repeat (300) cycle(1'b0, '0);
        check("ignored_done_pulses", done_cnt, 1);
        expect_rx(1, 8'hFF, 8'h00);

        // tx_start held high: two back-to-back frames.
        done_cnt  = 0;
        prev_done = 1'b0;
        n         = 0;
        while (done_cnt < 2 && n < 5000) begin
            cycle(1'b1, 8'h55);
            if (prev_done) check("gap_tx", bus.tx, 1'b0);
            prev_done = bus.tx_done;
            n++;
        end
        repeat (50) cycle(1'b0, '0);
        check("b2b_done_pulses", done_cnt, 2);
        expect_rx(2, 8'h55, 8'h55);

        // Loopback with irregular tick spacing.
        tick_per = -1;
        send_frame(8'h52);
        send_frame(8'h41);
        repeat (40) cycle(1'b0, '0);
        expect_rx(2, 8'h52, 8'h41);

        // Ticks stalled for 1000 clocks right after acceptance.
        tick_per = 0;
        cycle(1'b1, 8'h3C);
        repeat (1000) cycle(1'b0, DATA_BITS'($urandom));
        check("stall_tx", bus.tx, 1'b0);
        check("stall_busy", bus.tx_busy, 1'b1);
        tick_per   = 3;
        tick_phase = 0;
        wait_idle();
        repeat (10) cycle(1'b0, '0);
        expect_rx(1, 8'h3C, 8'h00);

        // Random bytes at random tick rates.
        for (int i = 0; i < 6; i++) begin
            rb         = DATA_BITS'($urandom);
            tick_per   = $urandom_range(1, 5);
            tick_phase = 0;
            repeat ($urandom_range(0, 3)) cycle(1'b0, '0);
            send_frame(rb);
            repeat (20) cycle(1'b0, '0);
            expect_rx(1, rb, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
